// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl: RV32I decode-stage control generator and ID/EX pipeline register
// Ports: clk, rst (async, active-high); id_valid/id_ready/id_inst/id_pc from the decode stage;
// flush kills the EX entry and the ID transfer; ex_ready/ex_valid handshake with EX;
// ex_* are the registered control fields and sign-extended immediate; stall_cnt is a
// saturating count of load-use stall cycles.
// Optional: define CTRL_MULDIV_EN to decode OP with funct7=0000001 as MULDIV (alu_op 6).
module id_ex_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_inst,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [2:0]       ex_alu_op,
    output logic [1:0]       ex_branch,
    output logic             ex_alu_src,
    output logic             ex_pc_to_reg_src,
    output logic             ex_rd_src,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_t;

    logic [6:0]        opc;
    logic [4:0]        rs1, rs2, rd;
    imm_t              imm_sel;
    logic [2:0]        alu_op;
    logic [1:0]        branch;
    logic              alu_src, pc_to_reg_src, rd_src, mem_to_reg, mem_read, mem_write;
    logic              reg_write, illegal, uses_rs2, load_use;
    logic signed [31:0] imm32;
    logic              rw_q, mr_q, mw_q;

    assign opc = id_inst[6:0];
    assign rd  = id_inst[11:7];
    assign rs1 = id_inst[19:15];
    assign rs2 = id_inst[24:20];

    always_comb begin
        imm_sel       = IMM_NONE;
        alu_op        = 3'd0;
        branch        = 2'b00;
        alu_src       = 1'b0;
        pc_to_reg_src = 1'b0;
        rd_src        = 1'b0;
        mem_to_reg    = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        illegal       = 1'b0;
        uses_rs2      = 1'b0;
        case (opc)
            OP_R: begin
                alu_src  = 1'b1;
                uses_rs2 = 1'b1;
                if (id_inst[31:25] == 7'b0000001) begin
`ifdef CTRL_MULDIV_EN
                    alu_op    = 3'd6;
                    reg_write = 1'b1;
`else
                    illegal = 1'b1;
`endif
                end else begin
                    reg_write = 1'b1;
                end
            end
            OP_I: begin
                imm_sel   = IMM_I;
                alu_op    = 3'd1;
                reg_write = 1'b1;
            end
            OP_LOAD: begin
                imm_sel    = IMM_I;
                alu_op     = 3'd2;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            OP_STORE: begin
                imm_sel   = IMM_S;
                alu_op    = 3'd2;
                mem_write = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_BRANCH: begin
                imm_sel  = IMM_B;
                alu_op   = 3'd3;
                branch   = 2'b01;
                alu_src  = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                imm_sel   = IMM_J;
                alu_op    = 3'd5;
                branch    = 2'b11;
                rd_src    = 1'b1;
                reg_write = 1'b1;
            end
            OP_JALR: begin
                imm_sel   = IMM_I;
                alu_op    = 3'd5;
                branch    = 2'b10;
                rd_src    = 1'b1;
                reg_write = 1'b1;
            end
            OP_LUI: begin
                imm_sel   = IMM_U;
                alu_op    = 3'd4;
                reg_write = 1'b1;
            end
            OP_AUIPC: begin
                imm_sel       = IMM_U;
                alu_op        = 3'd2;
                pc_to_reg_src = 1'b1;
                reg_write     = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (imm_sel)
            IMM_I:   imm32 = {{20{id_inst[31]}}, id_inst[31:20]};
            IMM_S:   imm32 = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
            IMM_B:   imm32 = {{19{id_inst[31]}}, id_inst[31], id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
            IMM_J:   imm32 = {{11{id_inst[31]}}, id_inst[31], id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};
            IMM_U:   imm32 = {id_inst[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    // The hazard is evaluated against the raw ID word even without id_valid, so id_ready
    // already reflects the stall when the instruction shows up.
    assign load_use = ex_valid && mr_q && ex_rd != 5'd0 &&
                      (ex_rd == rs1 || (ex_rd == rs2 && uses_rs2));
    assign id_ready = (!ex_valid || ex_ready) && !load_use && !flush;

    assign ex_reg_write = ex_valid && rw_q;
    assign ex_mem_read  = ex_valid && mr_q;
    assign ex_mem_write = ex_valid && mw_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid         <= 1'b0;
            ex_pc            <= '0;
            ex_imm           <= '0;
            ex_alu_op        <= '0;
            ex_branch        <= '0;
            ex_alu_src       <= 1'b0;
            ex_pc_to_reg_src <= 1'b0;
            ex_rd_src        <= 1'b0;
            ex_mem_to_reg    <= 1'b0;
            mr_q             <= 1'b0;
            mw_q             <= 1'b0;
            rw_q             <= 1'b0;
            ex_funct3        <= '0;
            ex_funct7b5      <= 1'b0;
            ex_rs1           <= '0;
            ex_rs2           <= '0;
            ex_rd            <= '0;
            ex_illegal       <= 1'b0;
            stall_cnt        <= '0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (id_valid && id_ready) begin
                ex_valid         <= 1'b1;
                ex_pc            <= id_pc;
                ex_imm           <= XLEN'(imm32);
                ex_alu_op        <= alu_op;
                ex_branch        <= branch;
                ex_alu_src       <= alu_src;
                ex_pc_to_reg_src <= pc_to_reg_src;
                ex_rd_src        <= rd_src;
                ex_mem_to_reg    <= mem_to_reg;
                mr_q             <= mem_read;
                mw_q             <= mem_write;
                rw_q             <= reg_write && rd != 5'd0;
                ex_funct3        <= id_inst[14:12];
                ex_funct7b5      <= id_inst[30];
                ex_rs1           <= rs1;
                ex_rs2           <= rs2;
                ex_rd            <= rd;
                ex_illegal       <= illegal;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
            if (id_valid && load_use && !flush && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_id_ex_ctrl.sv
// tb_id_ex_ctrl: randomized and directed check of id_ex_ctrl against a behavioural model
module tb_id_ex_ctrl;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0, rst = 1'b1, id_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
    logic [31:0] id_inst = '0, id_pc = '0;
    logic id_ready, ex_valid, ex_alu_src, ex_pc_to_reg_src, ex_rd_src, ex_mem_to_reg;
    logic ex_mem_read, ex_mem_write, ex_reg_write, ex_funct7b5, ex_illegal;
    logic [31:0] ex_pc, ex_imm;
    logic [2:0] ex_alu_op, ex_funct3;
    logic [1:0] ex_branch;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic [CW-1:0] stall_cnt;

    id_ex_ctrl #(.XLEN(32), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
        .id_pc(id_pc), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_imm(ex_imm), .ex_alu_op(ex_alu_op), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
        .ex_pc_to_reg_src(ex_pc_to_reg_src), .ex_rd_src(ex_rd_src), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  alu_op;
        logic [1:0]  branch;
        logic        alu_src, pc_to_reg, rd_src, mem_to_reg, mem_read, mem_write, reg_write;
        logic [2:0]  funct3;
        logic        f7b5;
        logic [4:0]  rs1, rs2, rd;
        logic        illegal;
    } e_t;

    e_t dut_e;
    assign dut_e = {ex_pc, ex_imm, ex_alu_op, ex_branch, ex_alu_src, ex_pc_to_reg_src, ex_rd_src,
                    ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_reg_write, ex_funct3, ex_funct7b5,
                    ex_rs1, ex_rs2, ex_rd, ex_illegal};

    int n_cmp = 0, n_bad = 0;
    e_t m = '0;
    logic m_valid = 1'b0;
    int m_cnt = 0;

    task automatic check(input string n, input logic [127:0] a, input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    function automatic logic uses_rs2(input logic [31:0] i);
        return i[6:0] == 7'h33 || i[6:0] == 7'h23 || i[6:0] == 7'h63;
    endfunction

    // Immediates are rebuilt arithmetically: arithmetic right shifts carry the sign, masks
    // clear the low bits, and the scattered fields are OR-ed back into place.
    function automatic e_t dec(input logic [31:0] i, input logic [31:0] pc);
        e_t e;
        int s, sh20, sh19, sh11;
        e = '0;
        s = $signed(i);
        sh20 = s >>> 20;
        sh19 = s >>> 19;
        sh11 = s >>> 11;
        e.pc = pc;
        e.funct3 = i[14:12];
        e.f7b5 = i[30];
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd = i[11:7];
        case (i[6:0])
            7'h33: begin
                e.alu_src = 1'b1;
                if (i[31:25] == 7'd1) begin
`ifdef CTRL_MULDIV_EN
                    e.alu_op = 3'd6;
                    e.reg_write = 1'b1;
`else
                    e.illegal = 1'b1;
`endif
                end else e.reg_write = 1'b1;
            end
            7'h13: begin e.imm = sh20; e.alu_op = 3'd1; e.reg_write = 1'b1; end
            7'h03: begin
                e.imm = sh20; e.alu_op = 3'd2;
                e.mem_read = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
            end
            7'h23: begin
                e.imm = (32'(sh20) & ~32'h1f) | 32'(i[11:7]);
                e.alu_op = 3'd2; e.mem_write = 1'b1;
            end
            7'h63: begin
                e.imm = (32'(sh19) & ~32'hfff) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
                e.alu_op = 3'd3; e.branch = 2'b01; e.alu_src = 1'b1;
            end
            7'h6f: begin
                e.imm = (32'(sh11) & ~32'hfffff) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
                e.alu_op = 3'd5; e.branch = 2'b11; e.rd_src = 1'b1; e.reg_write = 1'b1;
            end
            7'h67: begin
                e.imm = sh20; e.alu_op = 3'd5; e.branch = 2'b10;
                e.rd_src = 1'b1; e.reg_write = 1'b1;
            end
            7'h37: begin e.imm = i & 32'hfffff000; e.alu_op = 3'd4; e.reg_write = 1'b1; end
            7'h17: begin
                e.imm = i & 32'hfffff000; e.alu_op = 3'd2;
                e.pc_to_reg = 1'b1; e.reg_write = 1'b1;
            end
            7'h0f, 7'h73: ;
            default: e.illegal = 1'b1;
        endcase
        if (e.rd == 5'd0) e.reg_write = 1'b0;
        return e;
    endfunction

    function automatic e_t visible(input e_t x, input logic v);
        e_t r;
        r = x;
        if (!v) begin
            r.reg_write = 1'b0;
            r.mem_read = 1'b0;
            r.mem_write = 1'b0;
        end
        return r;
    endfunction

    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic fl, input logic er);
        logic lu, rdy;
        id_valid = v; id_inst = inst; id_pc = pc; flush = fl; ex_ready = er;
        @(negedge clk);
        lu = m_valid && m.mem_read && m.rd != 5'd0 &&
             (m.rd == inst[19:15] || (m.rd == inst[24:20] && uses_rs2(inst)));
        rdy = (!m_valid || er) && !lu && !fl;
        check("ex_valid", 128'(ex_valid), 128'(m_valid));
        check("ex_fields", 128'(dut_e), 128'(visible(m, m_valid)));
        check("id_ready", 128'(id_ready), 128'(rdy));
        check("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
        if (fl) m_valid = 1'b0;
        else if (v && rdy) begin m = dec(inst, pc); m_valid = 1'b1; end
        else if (er) m_valid = 1'b0;
        if (v && lu && !fl && m_cnt < SAT) m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        #2 rst = 1'b1;
        #1;
        check("async_rst", 128'({ex_valid, dut_e, stall_cnt}), 128'(0));
        m = '0; m_valid = 1'b0; m_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        logic [6:0] ops [12];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73, 7'h7f};
        i = $urandom;
        i[6:0] = ops[$urandom_range(0, 11)];
        if ($urandom_range(0, 7) == 0) i[6:0] = 7'($urandom);
        i[11:7] = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        if (i[6:0] == 7'h33) i[31:25] = $urandom_range(0, 2) == 0 ? 7'd1 : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
        return i;
    endfunction

    localparam logic [31:0] ADDI1 = 32'h00500093, LW2 = 32'h0000A103, ADD3 = 32'h002101B3;
    localparam logic [31:0] ADDI5 = 32'h00700293, BEQ = 32'hFE000EE3, MUL = 32'h022081B3;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(ex_valid), 128'(0));
        check("rst_fields", 128'(dut_e), 128'(0));
        check("rst_cnt", 128'(stall_cnt), 128'(0));
        check("rst_ready", 128'(id_ready), 128'(1));
        rst = 1'b0;

        step(1'b1, ADDI1, 32'h100, 1'b0, 1'b1);
        check("addi_valid", 128'(ex_valid), 128'(1));
        check("addi_imm", 128'(ex_imm), 128'(5));
        check("addi_rd", 128'(ex_rd), 128'(1));
        check("addi_op", 128'(ex_alu_op), 128'(1));
        check("addi_rw", 128'(ex_reg_write), 128'(1));

        step(1'b1, LW2, 32'h104, 1'b0, 1'b1);
        id_inst = ADD3;
        #1 check("lu_ready", 128'(id_ready), 128'(0));
        step(1'b1, ADD3, 32'h108, 1'b0, 1'b1);
        check("lu_bubble", 128'(ex_valid), 128'(0));
        check("lu_cnt", 128'(stall_cnt), 128'(1));
        step(1'b1, ADD3, 32'h108, 1'b0, 1'b1);
        check("lu_accept", 128'({ex_valid, ex_rd}), 128'({1'b1, 5'd3}));

        repeat (3) step(1'b1, ADDI5, 32'h10c, 1'b0, 1'b0);
        check("hold_rd", 128'({ex_valid, ex_rd, ex_pc}), 128'({1'b1, 5'd3, 32'h108}));
        check("hold_ready", 128'(id_ready), 128'(0));
        step(1'b1, ADDI5, 32'h10c, 1'b0, 1'b1);
        check("release", 128'({ex_rd, ex_imm}), 128'({5'd5, 32'd7}));

        step(1'b1, BEQ, 32'h110, 1'b1, 1'b1);
        check("flush_kill", 128'(ex_valid), 128'(0));
        step(1'b1, BEQ, 32'h110, 1'b0, 1'b1);
        check("beq", 128'({ex_valid, ex_branch, ex_imm}), 128'({1'b1, 2'b01, 32'hFFFFFFFC}));

        step(1'b1, 32'h0000007F, 32'h114, 1'b0, 1'b1);
        check("illegal", 128'({ex_illegal, ex_reg_write}), 128'({1'b1, 1'b0}));
        step(1'b1, MUL, 32'h118, 1'b0, 1'b1);
`ifdef CTRL_MULDIV_EN
        check("mul", 128'({ex_alu_op, ex_illegal, ex_reg_write}), 128'({3'd6, 1'b0, 1'b1}));
`else
        check("mul", 128'({ex_illegal, ex_reg_write}), 128'({1'b1, 1'b0}));
`endif
        step(1'b1, 32'h0000006F, 32'h11c, 1'b0, 1'b1);
        check("jal_x0", 128'({ex_branch, ex_reg_write}), 128'({2'b11, 1'b0}));

        step(1'b1, LW2, 32'h120, 1'b0, 1'b1);
        repeat (20) step(1'b1, ADD3, 32'h124, 1'b0, 1'b0);
        check("saturate", 128'(stall_cnt), 128'(SAT));
        pulse_rst();

        for (int k = 0; k < 4000; k++) begin
            step($urandom_range(0, 4) != 0, rand_inst(), $urandom & ~32'h3,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) pulse_rst();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
